// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - receive FIFO behind the UART receiver with strobe sync, overrun and irq
module uart_rx_buffer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int IRQ_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX_STATUS,
  input  logic [7:0]        RX_DATA,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [7:0]        rd_data,
  output logic              rx_valid,
  output logic              rx_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              irq
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IRQ_COUNT  = (ADDR_W + 1)'(IRQ_THRESH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              s1, s2, s3;
  logic              push;
  logic              pop;
  logic              do_write;
  logic              is_full;
  logic              is_empty;

  assign is_full  = (count == FULL_COUNT);
  assign is_empty = (count == '0);
  assign push     = s2 & ~s3;
  assign pop      = rd_en & ~is_empty;
  // A full FIFO still accepts a byte when the head is popped on the same edge.
  assign do_write = push & (~is_full | pop);

  // Chain resets high so a strobe already active at release is not seen as a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= RX_STATUS;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= RX_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_write && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !do_write) begin
        count <= count - 1'b1;
      end
    end
  end

  // Set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (push && is_full && !pop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign rd_data  = is_empty ? 8'h00 : mem[rd_ptr];
  assign rx_valid = ~is_empty;
  assign rx_full  = is_full;
  assign irq      = (count >= IRQ_COUNT) | overrun;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - directed vector bench for uart_rx_buffer
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX_STATUS;
  logic [7:0] RX_DATA;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       rx_full;
  logic [3:0] count;
  logic       overrun;
  logic       irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_buffer #(.DEPTH(8), .ADDR_W(3), .IRQ_THRESH(1)) dut (
    .clk(clk), .reset(reset), .RX_STATUS(RX_STATUS), .RX_DATA(RX_DATA),
    .rd_en(rd_en), .clr_overrun(clr_overrun), .rd_data(rd_data),
    .rx_valid(rx_valid), .rx_full(rx_full), .count(count),
    .overrun(overrun), .irq(irq)
  );

  typedef enum logic [2:0] {OP_PUSH, OP_POP, OP_CLR, OP_PUSH_POP, OP_PUSH_CLR} op_t;

  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic [3:0] exp_count;
    logic [7:0] exp_rd;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] c, input logic [7:0] d, input logic o);
    chk({tag, ".count"},    32'(count),    32'(c));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(d));
    chk({tag, ".overrun"},  32'(overrun),  32'(o));
    chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(c != 0));
    chk({tag, ".rx_full"},  32'(rx_full),  32'(c == 8));
    chk({tag, ".irq"},      32'(irq),      32'((c >= 1) || o));
  endtask

  // Strobe of 4 cycles high then 3 low; rd_en / clr_overrun land on the write edge.
  task automatic strobe(input logic [7:0] b, input logic with_pop, input logic with_clr);
    RX_DATA   = b;
    RX_STATUS = 1'b1;
    tick();
    tick();
    rd_en       = with_pop;
    clr_overrun = with_clr;
    tick();
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
    tick();
    RX_STATUS = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop_once();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{OP_PUSH, 8'(i + 1), 4'(i + 1), 8'h01, 1'b0};
    end
    vecs[8]  = '{OP_PUSH,      8'hFF, 4'd8, 8'h01, 1'b1};
    vecs[9]  = '{OP_CLR,       8'h00, 4'd8, 8'h01, 1'b0};
    vecs[10] = '{OP_PUSH_CLR,  8'hEE, 4'd8, 8'h01, 1'b1};
    vecs[11] = '{OP_CLR,       8'h00, 4'd8, 8'h01, 1'b0};
    vecs[12] = '{OP_PUSH_POP,  8'h77, 4'd8, 8'h02, 1'b0};
    for (int i = 13; i < 19; i++) begin
      vecs[i] = '{OP_POP, 8'h00, 4'(20 - i), 8'(i - 10), 1'b0};
    end
    vecs[19] = '{OP_POP,       8'h00, 4'd1, 8'h77, 1'b0};
    vecs[20] = '{OP_POP,       8'h00, 4'd0, 8'h00, 1'b0};
    vecs[21] = '{OP_POP,       8'h00, 4'd0, 8'h00, 1'b0};
    vecs[22] = '{OP_PUSH_POP,  8'h5A, 4'd1, 8'h5A, 1'b0};
    vecs[23] = '{OP_POP,       8'h00, 4'd0, 8'h00, 1'b0};

    reset = 1'b0; RX_STATUS = 1'b0; RX_DATA = 8'h00; rd_en = 1'b0; clr_overrun = 1'b0;
    repeat (3) tick();
    chk_state("reset", 4'd0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();

    // Long strobe: write lands on the third edge after RX_STATUS rises, exactly once.
    RX_DATA   = 8'hA5;
    RX_STATUS = 1'b1;
    tick();
    chk("lat.edge_k", 32'(count), 32'd0);
    tick();
    chk("lat.edge_k1", 32'(count), 32'd0);
    tick();
    chk_state("lat.edge_k2", 4'd1, 8'hA5, 1'b0);
    repeat (13) tick();
    chk("long_strobe.count", 32'(count), 32'd1);
    RX_STATUS = 1'b0;
    repeat (3) tick();
    pop_once();
    chk_state("drain_a5", 4'd0, 8'h00, 1'b0);

    for (int i = 0; i < 24; i++) begin
      case (vecs[i].op)
        OP_PUSH:     strobe(vecs[i].data, 1'b0, 1'b0);
        OP_POP:      pop_once();
        OP_CLR:      begin clr_overrun = 1'b1; tick(); clr_overrun = 1'b0; end
        OP_PUSH_POP: strobe(vecs[i].data, 1'b1, 1'b0);
        OP_PUSH_CLR: strobe(vecs[i].data, 1'b0, 1'b1);
        default:     tick();
      endcase
      chk_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_rd, vecs[i].exp_ovr);
    end

    // Wrap: one entry kept resident while 12 push/pop pairs walk the pointers round.
    strobe(8'h10, 1'b0, 1'b0);
    chk_state("wrap.start", 4'd1, 8'h10, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      strobe(8'(8'h10 + i), 1'b1, 1'b0);
      chk_state($sformatf("wrap%0d", i), 4'd1, 8'(8'h10 + i), 1'b0);
    end
    pop_once();
    chk_state("wrap.end", 4'd0, 8'h00, 1'b0);

    for (int i = 0; i < 5; i++) strobe(8'(8'hC0 + i), 1'b0, 1'b0);
    chk_state("pre_reset", 4'd5, 8'hC0, 1'b0);
    RX_DATA   = 8'h99;
    RX_STATUS = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_state("async_reset", 4'd0, 8'h00, 1'b0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk_state("held_strobe", 4'd0, 8'h00, 1'b0);
    RX_STATUS = 1'b0;
    repeat (3) tick();
    chk("after_low.count", 32'(count), 32'd0);
    strobe(8'h3C, 1'b0, 1'b0);
    chk_state("post_reset_push", 4'd1, 8'h3C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
